// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small address/size helpers used by the
// command master and its lane steering logic.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  // Command size 3 has no AHB meaning here and is issued as a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? 2'd2 : size;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] a;
    a = addr;
    if (size == 2'd1) begin
      a[0] = 1'b0;
    end else if (size != 2'd0) begin
      a[1:0] = 2'b00;
    end
    return a;
  endfunction

endpackage

// File: rtl/ahblite_lane_steer.sv
// Byte-lane steering: write data is replicated across all lanes, read data
// (already shifted down to bit 0) is masked to the transfer size.
module ahblite_lane_steer
  import ahb_pkg::*;
#(
  parameter bit READ = 1'b0
) (
  input  logic [1:0]  size,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  generate
    if (READ) begin : g_rd
      always_comb begin
        dout = din;
        case ({1'b0, size})
          HSIZE_BYTE: dout = {24'b0, din[7:0]};
          HSIZE_HALF: dout = {16'b0, din[15:0]};
          default:    dout = din;
        endcase
      end
    end else begin : g_wr
      always_comb begin
        dout = din;
        case ({1'b0, size})
          HSIZE_BYTE: dout = {4{din[7:0]}};
          HSIZE_HALF: dout = {2{din[15:0]}};
          default:    dout = din;
        endcase
      end
    end
  endgenerate

endmodule

// File: rtl/ahblite_cmd_master.sv
// AHB-Lite initiator: valid/ready commands become pipelined SINGLE transfers,
// one response pulse per command, in order.
module ahblite_cmd_master
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL    = 4'b0011,
  parameter int         ERRCNT_WIDTH = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             cmd_addr,
  input  logic                    cmd_write,
  input  logic [1:0]              cmd_size,
  input  logic [31:0]             cmd_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  output logic [31:0]             HADDR,
  output logic [1:0]              HTRANS,
  output logic [2:0]              HSIZE,
  output logic                    HWRITE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic                    HMASTLOCK,
  output logic [31:0]             HWDATA,
  input  logic                    HREADY,
  input  logic [31:0]             HRDATA,
  input  logic [1:0]              HRESP
);

  logic [31:0]             haddr_reg;
  logic [1:0]              htrans_reg;
  logic [2:0]              hsize_reg;
  logic                    hwrite_reg;
  logic [31:0]             ap_wdata_reg;

  logic                    dp_valid_reg;
  logic                    dp_write_reg;
  logic [1:0]              dp_size_reg;
  logic [1:0]              dp_addr_lo_reg;
  logic [31:0]             hwdata_reg;

  logic                    rsp_valid_reg;
  logic                    rsp_err_reg;
  logic [31:0]             rsp_rdata_reg;
  logic [ERRCNT_WIDTH-1:0] err_count_reg;

  logic [1:0]              cmd_size_norm;
  logic [31:0]             wdata_steered;
  logic [31:0]             rdata_shifted;
  logic [31:0]             rdata_steered;
  logic                    hresp_err;
  logic                    completing;

  assign cmd_size_norm = norm_size(cmd_size);
  // Only bit 0 of HRESP carries meaning for AHB-Lite.
  assign hresp_err     = (HRESP & 2'(HRESP_ERROR)) != 2'b00;
  assign rdata_shifted = HRDATA >> {dp_addr_lo_reg, 3'b000};
  assign completing    = HREADY && dp_valid_reg;

  ahblite_lane_steer #(.READ(1'b0)) u_wr_steer (
    .size (hsize_reg[1:0]),
    .din  (ap_wdata_reg),
    .dout (wdata_steered)
  );

  ahblite_lane_steer #(.READ(1'b1)) u_rd_steer (
    .size (dp_size_reg),
    .din  (rdata_shifted),
    .dout (rdata_steered)
  );

  // Address phase: only advances when the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_reg    <= '0;
      htrans_reg   <= HTRANS_IDLE;
      hsize_reg    <= '0;
      hwrite_reg   <= 1'b0;
      ap_wdata_reg <= '0;
    end else if (HREADY) begin
      if (cmd_valid) begin
        htrans_reg   <= HTRANS_NONSEQ;
        haddr_reg    <= align_addr(cmd_addr, cmd_size_norm);
        hsize_reg    <= {1'b0, cmd_size_norm};
        hwrite_reg   <= cmd_write;
        ap_wdata_reg <= cmd_wdata;
      end else begin
        htrans_reg   <= HTRANS_IDLE;
      end
    end
  end

  // Data phase: captures whatever address phase just completed.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid_reg   <= 1'b0;
      dp_write_reg   <= 1'b0;
      dp_size_reg    <= '0;
      dp_addr_lo_reg <= '0;
      hwdata_reg     <= '0;
    end else if (HREADY) begin
      dp_valid_reg   <= (htrans_reg == HTRANS_NONSEQ);
      dp_write_reg   <= hwrite_reg;
      dp_size_reg    <= hsize_reg[1:0];
      dp_addr_lo_reg <= haddr_reg[1:0];
      hwdata_reg     <= wdata_steered;
    end
  end

  // The first ERROR cycle has HREADY low, so it falls through as a wait state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      err_count_reg <= '0;
    end else if (completing) begin
      rsp_valid_reg <= 1'b1;
      rsp_err_reg   <= hresp_err;
      rsp_rdata_reg <= dp_write_reg ? 32'h0 : rdata_steered;
      if (hresp_err && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + ERRCNT_WIDTH'(1);
      end
    end else begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign cmd_ready = HREADY;
  assign HADDR     = haddr_reg;
  assign HTRANS    = htrans_reg;
  assign HSIZE     = hsize_reg;
  assign HWRITE    = hwrite_reg;
  assign HWDATA    = hwdata_reg;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Directed bench for ahblite_cmd_master: single-transfer vector table plus
// cycle tables for pipelined stalls, ERROR responses, saturation and reset.
module tb_ahblite_cmd_master;

  logic        HCLK;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_count;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ahblite_cmd_master #(.HPROT_VAL(4'b0011), .ERRCNT_WIDTH(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        cw;
    logic [31:0] ca;
    logic [1:0]  cs;
    logic [31:0] cwd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [31:0] e_hwd;
    logic [31:0] e_rdata;
  } vec_t;

  typedef struct {
    logic        cv;
    logic        cw;
    logic [31:0] ca;
    logic [1:0]  cs;
    logic [31:0] cwd;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_crdy;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [7:0]  e_ec;
    logic        e_hwd_chk;
    logic [31:0] e_hwd;
  } step_t;

  vec_t  vecs[10];
  step_t steps[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic step_t mk(input logic cv, input logic cw, input logic [31:0] ca,
                               input logic [1:0] cs, input logic [31:0] cwd, input logic rdy,
                               input logic [1:0] resp, input logic [31:0] rd,
                               input logic [1:0] e_trans, input logic [31:0] e_addr,
                               input logic e_crdy, input logic e_rv, input logic e_err,
                               input logic [31:0] e_rdata, input logic [7:0] e_ec,
                               input logic e_hwd_chk, input logic [31:0] e_hwd);
    step_t s;
    s.cv = cv; s.cw = cw; s.ca = ca; s.cs = cs; s.cwd = cwd;
    s.rdy = rdy; s.resp = resp; s.rd = rd;
    s.e_trans = e_trans; s.e_addr = e_addr; s.e_crdy = e_crdy; s.e_rv = e_rv;
    s.e_err = e_err; s.e_rdata = e_rdata; s.e_ec = e_ec;
    s.e_hwd_chk = e_hwd_chk; s.e_hwd = e_hwd;
    return s;
  endfunction

  // Called #1 after a rising edge; each step covers exactly one clock cycle.
  task automatic run_steps(input string tag);
    foreach (steps[i]) begin
      cmd_valid = steps[i].cv; cmd_write = steps[i].cw; cmd_addr = steps[i].ca;
      cmd_size = steps[i].cs; cmd_wdata = steps[i].cwd;
      HREADY = steps[i].rdy; HRESP = steps[i].resp; HRDATA = steps[i].rd;
      #1;
      chk($sformatf("%s[%0d].htrans", tag, i), 32'(HTRANS), 32'(steps[i].e_trans));
      if (steps[i].e_trans == 2'b10)
        chk($sformatf("%s[%0d].haddr", tag, i), HADDR, steps[i].e_addr);
      chk($sformatf("%s[%0d].cmd_ready", tag, i), 32'(cmd_ready), 32'(steps[i].e_crdy));
      chk($sformatf("%s[%0d].rsp_valid", tag, i), 32'(rsp_valid), 32'(steps[i].e_rv));
      if (steps[i].e_rv) begin
        chk($sformatf("%s[%0d].rsp_err", tag, i), 32'(rsp_err), 32'(steps[i].e_err));
        chk($sformatf("%s[%0d].rsp_rdata", tag, i), rsp_rdata, steps[i].e_rdata);
      end
      chk($sformatf("%s[%0d].err_count", tag, i), 32'(err_count), 32'(steps[i].e_ec));
      if (steps[i].e_hwd_chk)
        chk($sformatf("%s[%0d].hwdata", tag, i), HWDATA, steps[i].e_hwd);
      $display("%s step %0d: htrans=%0d haddr=%08h rsp_valid=%0b rdata=%08h",
               tag, i, HTRANS, HADDR, rsp_valid, rsp_rdata);
      @(posedge HCLK); #1;
    end
    steps.delete();
  endtask

  initial begin
    int n_err;
    int n_rv;

    vecs[0] = '{1'b1, 32'h2000_0010, 2'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h2000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h2000_0010, 2'd2, 32'h0,         32'hDEAD_BEEF, 32'h2000_0010, 3'd2, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h2000_0003, 2'd0, 32'h0000_005A, 32'hFFFF_FFFF, 32'h2000_0003, 3'd0, 32'h5A5A_5A5A, 32'h0};
    vecs[3] = '{1'b0, 32'h2000_0001, 2'd0, 32'h0,         32'h1234_5678, 32'h2000_0001, 3'd0, 32'h0,         32'h0000_0056};
    vecs[4] = '{1'b1, 32'h2000_0007, 2'd1, 32'hBEEF_1234, 32'hFFFF_FFFF, 32'h2000_0006, 3'd1, 32'h1234_1234, 32'h0};
    vecs[5] = '{1'b0, 32'h2000_0006, 2'd1, 32'h0,         32'hCAFE_F00D, 32'h2000_0006, 3'd1, 32'h0,         32'h0000_CAFE};
    vecs[6] = '{1'b0, 32'h2000_000B, 2'd3, 32'h0,         32'h89AB_CDEF, 32'h2000_0008, 3'd2, 32'h0,         32'h89AB_CDEF};
    vecs[7] = '{1'b0, 32'h2000_0002, 2'd0, 32'h0,         32'h1234_5678, 32'h2000_0002, 3'd0, 32'h0,         32'h0000_0034};
    vecs[8] = '{1'b1, 32'h1000_0006, 2'd2, 32'h0102_0304, 32'hFFFF_FFFF, 32'h1000_0004, 3'd2, 32'h0102_0304, 32'h0};
    vecs[9] = '{1'b1, 32'h0000_0000, 2'd0, 32'hFFFF_FFA5, 32'hFFFF_FFFF, 32'h0000_0000, 3'd0, 32'hA5A5_A5A5, 32'h0};

    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
    cmd_wdata = '0; HREADY = 1'b1; HRDATA = '0; HRESP = 2'b00;
    #2;
    chk("reset.htrans", 32'(HTRANS), 32'h0);
    chk("reset.haddr", HADDR, 32'h0);
    chk("reset.hsize", 32'(HSIZE), 32'h0);
    chk("reset.hwrite", 32'(HWRITE), 32'h0);
    chk("reset.hwdata", HWDATA, 32'h0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset.rsp_rdata", rsp_rdata, 32'h0);
    chk("reset.rsp_err", 32'(rsp_err), 32'h0);
    chk("reset.err_count", 32'(err_count), 32'h0);
    chk("const.hburst", 32'(HBURST), 32'h0);
    chk("const.hprot", 32'(HPROT), 32'h3);
    chk("const.hmastlock", 32'(HMASTLOCK), 32'h0);
    chk("reset.cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Single transfers: accept edge, NONSEQ after it, HWDATA after the next,
    // response after the one following (third cycle after accept).
    foreach (vecs[i]) begin
      cmd_valid = 1'b1; cmd_write = vecs[i].cw; cmd_addr = vecs[i].ca;
      cmd_size = vecs[i].cs; cmd_wdata = vecs[i].cwd; HREADY = 1'b1; HRESP = 2'b00;
      #1;
      chk($sformatf("v%0d.cmd_ready", i), 32'(cmd_ready), 32'h1);
      @(posedge HCLK); #1;
      cmd_valid = 1'b0;
      chk($sformatf("v%0d.htrans", i), 32'(HTRANS), 32'h2);
      chk($sformatf("v%0d.haddr", i), HADDR, vecs[i].e_addr);
      chk($sformatf("v%0d.hsize", i), 32'(HSIZE), 32'(vecs[i].e_size));
      chk($sformatf("v%0d.hwrite", i), 32'(HWRITE), 32'(vecs[i].cw));
      @(posedge HCLK); #1;
      if (vecs[i].cw) chk($sformatf("v%0d.hwdata", i), HWDATA, vecs[i].e_hwd);
      chk($sformatf("v%0d.rsp_early", i), 32'(rsp_valid), 32'h0);
      HRDATA = vecs[i].rd;
      @(posedge HCLK); #1;
      chk($sformatf("v%0d.rsp_valid", i), 32'(rsp_valid), 32'h1);
      chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d.rsp_err", i), 32'(rsp_err), 32'h0);
      $display("vec %0d: addr=%08h write=%0b haddr=%08h rdata=%08h", i, vecs[i].ca, vecs[i].cw, HADDR, rsp_rdata);
      @(posedge HCLK); #1;
      chk($sformatf("v%0d.rsp_pulse", i), 32'(rsp_valid), 32'h0);
    end

    // Four back-to-back reads, two wait states on the second data phase.
    steps.push_back(mk(1,0,32'h3000_0000,2,0,1,0,32'h0,        2'b00,32'h0,        1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h3000_0004,2,0,1,0,32'h0,        2'b10,32'h3000_0000,1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h3000_0008,2,0,1,0,32'h1111_1111,2'b10,32'h3000_0004,1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h3000_000C,2,0,0,0,32'hDEAD_0000,2'b10,32'h3000_0008,0,1,0,32'h1111_1111,8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h3000_000C,2,0,0,0,32'hDEAD_0001,2'b10,32'h3000_0008,0,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h3000_000C,2,0,1,0,32'h2222_2222,2'b10,32'h3000_0008,1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,0,1,0,32'h3333_3333,2'b10,32'h3000_000C,1,1,0,32'h2222_2222,8'd0,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,0,1,0,32'h4444_4444,2'b00,32'h0,        1,1,0,32'h3333_3333,8'd0,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,0,1,0,32'h0,        2'b00,32'h0,        1,1,0,32'h4444_4444,8'd0,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,0,1,0,32'h0,        2'b00,32'h0,        1,0,0,32'h0,        8'd0,0,32'h0));
    run_steps("b2b");

    // Two-cycle ERROR on a write with a pipelined read behind it.
    steps.push_back(mk(1,1,32'h4000_0000,2,32'hCAFE_0001,1,2'b00,32'h0,        2'b00,32'h0,        1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(1,0,32'h4000_0004,2,32'h0,        1,2'b00,32'h0,        2'b10,32'h4000_0000,1,0,0,32'h0,        8'd0,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,32'h0,        0,2'b01,32'hFFFF_FFFF,2'b10,32'h4000_0004,0,0,0,32'h0,        8'd0,1,32'hCAFE_0001));
    steps.push_back(mk(0,0,32'h0,        2,32'h0,        1,2'b01,32'hFFFF_FFFF,2'b10,32'h4000_0004,1,0,0,32'h0,        8'd0,1,32'hCAFE_0001));
    steps.push_back(mk(0,0,32'h0,        2,32'h0,        1,2'b00,32'h7654_3210,2'b00,32'h0,        1,1,1,32'h0,        8'd1,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,32'h0,        1,2'b00,32'h0,        2'b00,32'h0,        1,1,0,32'h7654_3210,8'd1,0,32'h0));
    steps.push_back(mk(0,0,32'h0,        2,32'h0,        1,2'b00,32'h0,        2'b00,32'h0,        1,0,0,32'h0,        8'd1,0,32'h0));
    run_steps("err");

    // Saturation: stream writes with every other cycle a wait, all ERROR.
    n_err = 0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000_0000; cmd_size = 2'd2; HRESP = 2'b01;
    for (int i = 0; i < 600; i++) begin
      HREADY = (i % 2 == 1);
      @(posedge HCLK); #1;
      if (rsp_valid && rsp_err) begin
        n_err++;
        if (n_err == 100 || n_err == 253 || n_err == 254)
          chk($sformatf("sat.err_count@%0d", n_err), 32'(err_count), (n_err + 1 > 255) ? 32'd255 : 32'(n_err + 1));
      end
    end
    cmd_valid = 1'b0; HRESP = 2'b00; HREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
    end
    chk("sat.error_pulses_ge_260", 32'(n_err >= 260), 32'h1);
    chk("sat.err_count_final", 32'(err_count), 32'd255);
    $display("saturation: %0d error responses, err_count=%0d", n_err, err_count);

    // Reset while the data phase of B is stalled and C sits in the address phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h5000_0000; HREADY = 1'b1;
    @(posedge HCLK); #1;
    cmd_addr = 32'h5000_0004;
    @(posedge HCLK); #1;
    cmd_addr = 32'h5000_0008; HRDATA = 32'h0BAD_F00D;
    @(posedge HCLK); #1;
    cmd_valid = 1'b0; HREADY = 1'b0;
    chk("rst.pre_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rst.pre_htrans", 32'(HTRANS), 32'h2);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("rst.async_htrans", 32'(HTRANS), 32'h0);
    chk("rst.async_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.async_haddr", HADDR, 32'h0);
    chk("rst.async_err_count", 32'(err_count), 32'h0);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1; HREADY = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge HCLK); #1;
      if (rsp_valid) n_rv++;
    end
    chk("rst.no_rsp_after_release", 32'(n_rv), 32'h0);
    chk("rst.idle_after_release", 32'(HTRANS), 32'h0);
    $display("reset: responses after release=%0d htrans=%0d", n_rv, HTRANS);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahblite_cmd_master.md
# ahblite_cmd_master

AHB-Lite initiator that turns a simple valid/ready command stream into single AHB-Lite transfers and returns one response per command. It drives the system AHB-Lite bus towards the slaves (block RAM/ROM, peripherals) from on-chip engines such as a boot loader, test sequencer or debug bridge. Address and data phases overlap, so throughput is one transfer per cycle with zero-wait slaves. HREADY wait states and ERROR responses are handled.

## Interface
- HPROT_VAL, 4'b0011, constant driven on HPROT (data, privileged)
- ERRCNT_WIDTH, 8, width of the saturating error counter
- HCLK  in  1  bus clock; all logic is on the rising edge
- HRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on the edge where cmd_valid && cmd_ready
- cmd_addr  in  32  byte address
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- cmd_wdata  in  32  write data, right-justified (LSBs)
- rsp_valid  out  1  one-cycle pulse, one per accepted command, in order
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes
- rsp_err  out  1  slave returned ERROR
- err_count  out  ERRCNT_WIDTH  number of ERROR responses, saturating
- HADDR  out  32, HTRANS  out  2, HSIZE  out  3, HWRITE  out  1, HBURST  out  3, HPROT  out  4, HMASTLOCK  out  1, HWDATA  out  32  AHB-Lite master outputs
- HREADY  in  1  bus ready, from the interconnect
- HRDATA  in  32  read data
- HRESP  in  2  bit 0 = ERROR, bit 1 ignored

## Operation
- Reset values:
  - HTRANS=IDLE(00), HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, err_count=0
  - Internal data-phase valid flag = 0
- Constant outputs: HBURST=000 (SINGLE), HMASTLOCK=0, HPROT=HPROT_VAL.
- cmd_ready = HREADY, combinational. While HREADY=0, all address-phase outputs hold.
- Address phase, on an edge with HREADY=1:
  - If cmd_valid: the address-phase registers load the command, with HTRANS=NONSEQ.
  - HADDR is cmd_addr with its low bits forced to zero for the size: bit 0 cleared for half; bits 1:0 cleared for word.
  - Otherwise the registers load HTRANS=IDLE; HADDR/HSIZE/HWRITE hold.
  - Only NONSEQ and IDLE are ever driven. BUSY and SEQ never appear.
- Data phase, on the same HREADY=1 edge:
  - The data-phase registers take the completing address phase: valid = (HTRANS==NONSEQ), write, size, addr[1:0], and steered wdata.
  - HWDATA is driven from the data-phase register and holds through wait states.
- Write lane steering:
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: unchanged.
- Completion, on an edge with HREADY=1 and data-phase valid=1:
  - rsp_valid=1 for the next cycle.
  - rsp_err=HRESP[0].
  - For reads, rsp_rdata = HRDATA >> (8·addr[1:0]), masked to the size width. Writes return 0.
- ERROR (two-cycle response):
  - The first cycle (HREADY=0, HRESP[0]=1) is treated as a wait state.
  - Completion is taken on the second cycle (HREADY=1).
  - A pipelined next transfer is not cancelled and proceeds normally.
- err_count increments on each completion with rsp_err=1 and saturates at all-ones.
- Reset mid-operation: everything returns to reset values immediately. In-flight commands produce no response.

## Timing
- Command accepted at edge k with zero-wait slave:
  - NONSEQ visible on HTRANS in cycle k+1.
  - Data phase in cycle k+2.
  - rsp_valid in cycle k+3. Latency is 3 cycles.
- Each HREADY=0 cycle in either phase adds one cycle.
- Back-to-back commands give one rsp_valid per cycle, in order.
- No response backpressure: the consumer must take rsp_valid when it occurs.
- HREADY low with cmd_valid high: no accept; the command must stay stable until cmd_ready.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HSIZE_BYTE/HALF/WORD
  - HBURST_SINGLE
  - HRESP_OKAY/ERROR
- Sub-module ahblite_lane_steer (combinational) does write replication and read extraction. Instantiate it once for each direction.

## Test plan
- Word write then read at 0x2000_0010, data 0xDEADBEEF, zero-wait slave:
  - HTRANS=NONSEQ one cycle after accept; HWDATA=0xDEADBEEF in the next cycle.
  - Read rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid 3 cycles after its accept.
- Byte write 0x5A to addr 0x...03 → HSIZE=0, HADDR low bits 11, HWDATA=0x5A5A5A5A. Byte read, HRDATA=0x12345678, addr low bits 01 → rsp_rdata=0x00000056.
- 4 back-to-back reads, slave inserts 2 wait states on the 2nd data phase:
  - HADDR/HTRANS hold during the stall, and cmd_ready=0 during the stall.
  - 4 in-order rsp_valid pulses, total 4+2+2 cycles.
- Two-cycle ERROR on a write → rsp_err=1, err_count 0→1. The pipelined following read still completes with rsp_err=0.
- Counter saturation: 260 ERROR responses with ERRCNT_WIDTH=8 → err_count stays 255.
- HRESETn asserted during a stalled data phase → HTRANS=IDLE and rsp_valid=0 asynchronously. No response is produced after reset release.
